// File: rtl/irq_timer_gen.sv
// Multi-channel periodic interrupt timer with pulse and level/EOI modes.
// Each channel counts 0..period, firing once per period+1 cycles.
module irq_timer_gen #(
   parameter int NUM_CH    = 2,
   parameter int CNT_WIDTH = 16,
   parameter int IRQ_BASE  = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cfg_we,
   input  logic [2:0]           cfg_ch,
   input  logic                 cfg_en,
   input  logic                 cfg_level,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   input  logic [31:0]          eoi,
   input  logic [2:0]           sts_ch,
   output logic [7:0]           sts_missed,
   output logic                 sts_pending,
   output logic [31:0]          irq
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

   logic [NUM_CH-1:0]    en_q, en_d;
   logic [NUM_CH-1:0]    lvl_q, lvl_d;
   logic [NUM_CH-1:0]    pend_q, pend_d;
   logic [NUM_CH-1:0]    pulse_q, pulse_d;
   logic [NUM_CH-1:0]    fire, ack, wr;
   logic [CNT_WIDTH-1:0] per_q [NUM_CH];
   logic [CNT_WIDTH-1:0] per_d [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
   logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
   logic [7:0]           miss_q [NUM_CH];
   logic [7:0]           miss_d [NUM_CH];
   logic [7:0]           sts_missed_q, sts_missed_d;
   logic                 sts_pending_q, sts_pending_d;
   logic                 unused_eoi;

   // Only the channel window of eoi matters; the rest is folded here.
   assign unused_eoi = ^eoi;

   always_comb begin
      fire = '0;
      ack  = '0;
      wr   = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         fire[k] = en_q[k] && (cnt_q[k] == per_q[k]);
         ack[k]  = lvl_q[k] && eoi[IRQ_BASE+k];
         wr[k]   = cfg_we && (cfg_ch == 3'(k));
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         en_d[k]    = en_q[k];
         lvl_d[k]   = lvl_q[k];
         per_d[k]   = per_q[k];
         pend_d[k]  = pend_q[k];
         miss_d[k]  = miss_q[k];
         pulse_d[k] = fire[k] && !lvl_q[k];
         if (!en_q[k] || fire[k]) begin
            cnt_d[k] = '0;
         end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
         end
         if (lvl_q[k]) begin
            if (fire[k]) begin
               pend_d[k] = 1'b1;
               if (pend_q[k] && !ack[k] && miss_q[k] != 8'hff) begin
                  miss_d[k] = miss_q[k] + 8'd1;
               end
            end else if (ack[k]) begin
               pend_d[k] = 1'b0;
            end
         end
         // A config write wins over any fire or eoi on the same edge.
         if (wr[k]) begin
            en_d[k]    = cfg_en;
            lvl_d[k]   = cfg_level;
            per_d[k]   = cfg_period;
            cnt_d[k]   = '0;
            pend_d[k]  = 1'b0;
            miss_d[k]  = '0;
            pulse_d[k] = 1'b0;
         end
      end
   end

   always_comb begin
      sts_missed_d  = '0;
      sts_pending_d = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sts_ch == 3'(k)) begin
            sts_missed_d  = miss_q[k];
            sts_pending_d = pend_q[k];
         end
      end
   end

   always_comb begin
      irq = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         irq[IRQ_BASE+k] = pulse_q[k] | pend_q[k];
      end
   end

   assign sts_missed  = sts_missed_q;
   assign sts_pending = sts_pending_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q          <= '0;
         lvl_q         <= '0;
         pend_q        <= '0;
         pulse_q       <= '0;
         sts_missed_q  <= '0;
         sts_pending_q <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            per_q[k]  <= '1;
            cnt_q[k]  <= '0;
            miss_q[k] <= '0;
         end
      end else begin
         en_q          <= en_d;
         lvl_q         <= lvl_d;
         pend_q        <= pend_d;
         pulse_q       <= pulse_d;
         sts_missed_q  <= sts_missed_d;
         sts_pending_q <= sts_pending_d;
         for (int k = 0; k < NUM_CH; k++) begin
            per_q[k]  <= per_d[k];
            cnt_q[k]  <= cnt_d[k];
            miss_q[k] <= miss_d[k];
         end
      end
   end

endmodule

// File: tb/tb_irq_timer_gen.sv
// Bench for irq_timer_gen: arithmetic reference model compared every cycle,
// plus literal checkpoints at hand-computed cycles.
module tb_irq_timer_gen;

   localparam int NCH  = 2;
   localparam int CW   = 16;
   localparam int BASE = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          cfg_we;
   logic [2:0]    cfg_ch;
   logic          cfg_en;
   logic          cfg_level;
   logic [CW-1:0] cfg_period;
   logic [31:0]   eoi;
   logic [2:0]    sts_ch;
   logic [7:0]    sts_missed;
   logic          sts_pending;
   logic [31:0]   irq;

   irq_timer_gen #(
      .NUM_CH(NCH), .CNT_WIDTH(CW), .IRQ_BASE(BASE)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
      .cfg_level(cfg_level), .cfg_period(cfg_period),
      .eoi(eoi), .sts_ch(sts_ch),
      .sts_missed(sts_missed), .sts_pending(sts_pending),
      .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (time %0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a channel written at edge count w fires in every
   // cycle where (t - w) mod (period+1) == period.
   int          t = 0;
   bit          m_en   [8];
   bit          m_lvl  [8];
   int          m_per  [8];
   int          m_wt   [8];
   bit          m_pend [8];
   int          m_miss [8];
   logic [31:0] e_irq;
   logic [7:0]  e_sm;
   logic        e_sp;

   always @(posedge clk) begin
      bit f;
      bit a;
      if (reset) begin
         for (int k = 0; k < 8; k++) begin
            m_en[k] = 0; m_lvl[k] = 0; m_per[k] = 65535;
            m_wt[k] = 0; m_pend[k] = 0; m_miss[k] = 0;
         end
         e_irq = '0; e_sm = '0; e_sp = 1'b0;
      end else begin
         e_sm = (sts_ch < NCH) ? 8'(m_miss[sts_ch]) : 8'd0;
         e_sp = (sts_ch < NCH) ? m_pend[sts_ch] : 1'b0;
         e_irq = '0;
         for (int k = 0; k < NCH; k++) begin
            f = m_en[k] && ((t - m_wt[k]) % (m_per[k] + 1) == m_per[k]);
            a = eoi[BASE+k];
            if (cfg_we && cfg_ch == 3'(k)) begin
               m_en[k] = cfg_en; m_lvl[k] = cfg_level;
               m_per[k] = int'(cfg_period); m_wt[k] = t + 1;
               m_pend[k] = 0; m_miss[k] = 0;
            end else if (m_lvl[k]) begin
               if (f) begin
                  if (m_pend[k] && !a && m_miss[k] < 255) m_miss[k]++;
                  m_pend[k] = 1;
               end else if (a) begin
                  m_pend[k] = 0;
               end
            end else if (f) begin
               e_irq[BASE+k] = 1'b1;
            end
            if (m_pend[k]) e_irq[BASE+k] = 1'b1;
         end
      end
      t++;
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("irq", irq, e_irq);
         check("sts_missed", 32'(sts_missed), 32'(e_sm));
         check("sts_pending", 32'(sts_pending), 32'(e_sp));
         check("irq_outside", irq & ~32'h30, 32'h0);
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(int ch, bit en, bit lvl, int per);
      cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_en = en;
      cfg_level = lvl; cfg_period = CW'(per);
      step(1);
      cfg_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cfg_we = 0; cfg_ch = 0; cfg_en = 0;
      cfg_level = 0; cfg_period = 0; eoi = 0; sts_ch = 1;
      step(1);
      chk_on = 1'b1;
      step(1);
      reset = 1'b0;
      check("reset_irq", irq, 32'h0);
      check("reset_sts_missed", 32'(sts_missed), 32'h0);
      step(20);
      check("idle_irq", irq, 32'h0);

      // Pulse mode, period 8191: first pulse 8192 edges after the write.
      cfg(0, 1, 0, 8191);
      step(8191);
      check("pulse_early", 32'(irq[4]), 32'h0);
      step(1);
      check("pulse_first", 32'(irq[4]), 32'h1);
      step(1);
      check("pulse_width", 32'(irq[4]), 32'h0);
      step(8190);
      check("pulse_gap", 32'(irq[4]), 32'h0);
      step(1);
      check("pulse_second", 32'(irq[4]), 32'h1);
      step(1);

      // Level mode, period 3: rises 4 edges after write, held until EOI.
      cfg(1, 1, 1, 3);
      step(3);
      check("lvl_before", 32'(irq[5]), 32'h0);
      step(1);
      check("lvl_rise", 32'(irq[5]), 32'h1);
      step(2);
      check("lvl_hold", 32'(irq[5]), 32'h1);
      eoi = 32'h20;
      step(1);
      eoi = 32'h0;
      check("lvl_fall", 32'(irq[5]), 32'h0);
      check("lvl_missed0", 32'(sts_missed), 32'h0);
      step(1);
      check("lvl_refire", 32'(irq[5]), 32'h1);

      // EOI on the fire cycle keeps pending and does not count a miss.
      step(3);
      eoi = 32'h20;
      step(1);
      eoi = 32'h0;
      check("sim_pending", 32'(irq[5]), 32'h1);
      step(1);
      check("sim_missed", 32'(sts_missed), 32'h0);
      check("sim_sts_pend", 32'(sts_pending), 32'h1);

      // Config write on a would-be miss cycle clears everything.
      step(2);
      cfg(1, 1, 1, 3);
      check("cfgwin_irq", 32'(irq[5]), 32'h0);
      step(1);
      check("cfgwin_missed", 32'(sts_missed), 32'h0);
      check("cfgwin_pend", 32'(sts_pending), 32'h0);
      step(3);
      check("cfgwin_rise", 32'(irq[5]), 32'h1);

      // Saturation of the missed counter.
      cfg(1, 1, 1, 0);
      step(300);
      check("sat_irq", 32'(irq[5]), 32'h1);
      check("sat_missed", 32'(sts_missed), 32'd255);

      // Out-of-range config and stray eoi bits.
      cfg(7, 0, 0, 5);
      for (int i = 0; i < 40; i++) begin
         eoi = $urandom & ~32'h20;
         sts_ch = 3'(i % 8);
         step(1);
      end
      eoi = 32'h0;
      sts_ch = 3'd7;
      step(2);
      check("sts_oor_missed", 32'(sts_missed), 32'h0);
      check("sts_oor_pend", 32'(sts_pending), 32'h0);
      sts_ch = 3'd1;
      step(1);
      check("still_sat", 32'(sts_missed), 32'd255);

      // Reset mid-operation with ch1 pending.
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check("rst_irq", irq, 32'h0);
      check("rst_missed", 32'(sts_missed), 32'h0);
      check("rst_pend", 32'(sts_pending), 32'h0);
      step(100);
      check("rst_quiet", irq, 32'h0);

      cfg(1, 1, 0, 2);
      step(3);
      check("reprog_pulse", 32'(irq[5]), 32'h1);
      step(10);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
